// File: rtl/mem_stage_if.sv
// Handshake and payload signals between the MEM stage and its EXE/WB/ID/SRAM neighbours.
// The slave modport is the MEM stage itself; master is the surrounding pipeline.
interface mem_stage_if;
    logic        exe_to_mem_valid;
    logic [73:0] exe_to_mem_bus;
    logic        mem_allow_in;
    logic        wb_allow_in;
    logic        mem_to_wb_valid;
    logic [69:0] mem_to_wb_bus;
    logic [38:0] mem_to_id_bus;
    logic [31:0] data_sram_rdata;

    modport master (
        output exe_to_mem_valid,
        output exe_to_mem_bus,
        output wb_allow_in,
        output data_sram_rdata,
        input  mem_allow_in,
        input  mem_to_wb_valid,
        input  mem_to_wb_bus,
        input  mem_to_id_bus
    );

    modport slave (
        input  exe_to_mem_valid,
        input  exe_to_mem_bus,
        input  wb_allow_in,
        input  data_sram_rdata,
        output mem_allow_in,
        output mem_to_wb_valid,
        output mem_to_wb_bus,
        output mem_to_id_bus
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: latches the EXE bus, aligns/extends load data and
// forwards the result to WB plus a bypass bus to ID, buffering SRAM rdata under stall.
module mem_stage (
    input  logic   clk,
    input  logic   resetn,
    mem_stage_if.slave bus_io
);
    localparam int unsigned ExeBusW = 74;

    localparam logic [2:0] LdW  = 3'b000;
    localparam logic [2:0] LdB  = 3'b001;
    localparam logic [2:0] LdH  = 3'b010;
    localparam logic [2:0] LdBu = 3'b011;
    localparam logic [2:0] LdHu = 3'b100;

    logic               mem_valid_q, mem_valid_d;
    logic [ExeBusW-1:0] mem_reg_q, mem_reg_d;
    logic               first_q, first_d;
    logic               buf_valid_q, buf_valid_d;
    logic [31:0]        rdata_buf_q, rdata_buf_d;

    logic        mem_allow_in;
    logic [31:0] pc;
    logic [31:0] alu_result;
    logic        res_from_mem;
    logic [2:0]  load_op;
    logic        reg_we;
    logic [4:0]  waddr;
    logic [31:0] eff_rdata;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_result;
    logic [31:0] final_result;

    assign {pc, alu_result, res_from_mem, load_op, reg_we, waddr} = mem_reg_q;

    // Ready-go is always 1, so MEM frees up whenever WB takes the current instruction.
    assign mem_allow_in = !mem_valid_q || bus_io.wb_allow_in;

    always_comb begin
        mem_valid_d = mem_valid_q;
        mem_reg_d   = mem_reg_q;
        first_d     = 1'b0;
        buf_valid_d = buf_valid_q;
        rdata_buf_d = rdata_buf_q;
        if (mem_allow_in) begin
            mem_valid_d = bus_io.exe_to_mem_valid;
        end
        if (mem_allow_in && bus_io.exe_to_mem_valid) begin
            mem_reg_d   = bus_io.exe_to_mem_bus;
            first_d     = 1'b1;
            buf_valid_d = 1'b0;
        end else if (mem_valid_q && first_q && !bus_io.wb_allow_in) begin
            // SRAM rdata lives for one cycle only; keep it while WB stalls.
            rdata_buf_d = bus_io.data_sram_rdata;
            buf_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_valid_q <= 1'b0;
            mem_reg_q   <= '0;
            first_q     <= 1'b0;
            buf_valid_q <= 1'b0;
            rdata_buf_q <= '0;
        end else begin
            mem_valid_q <= mem_valid_d;
            mem_reg_q   <= mem_reg_d;
            first_q     <= first_d;
            buf_valid_q <= buf_valid_d;
            rdata_buf_q <= rdata_buf_d;
        end
    end

    assign eff_rdata = buf_valid_q ? rdata_buf_q : bus_io.data_sram_rdata;

    always_comb begin
        load_byte = eff_rdata[7:0];
        unique case (alu_result[1:0])
            2'd0: load_byte = eff_rdata[7:0];
            2'd1: load_byte = eff_rdata[15:8];
            2'd2: load_byte = eff_rdata[23:16];
            2'd3: load_byte = eff_rdata[31:24];
            default: load_byte = eff_rdata[7:0];
        endcase
    end

    // Misaligned halfword/word accesses are not trapped; a[1] alone picks the half.
    assign load_half = alu_result[1] ? eff_rdata[31:16] : eff_rdata[15:0];

    always_comb begin
        load_result = eff_rdata;
        case (load_op)
            LdW:     load_result = eff_rdata;
            LdB:     load_result = {{24{load_byte[7]}}, load_byte};
            LdH:     load_result = {{16{load_half[15]}}, load_half};
            LdBu:    load_result = {24'd0, load_byte};
            LdHu:    load_result = {16'd0, load_half};
            default: load_result = eff_rdata;
        endcase
    end

    assign final_result = res_from_mem ? load_result : alu_result;

    assign bus_io.mem_allow_in    = mem_allow_in;
    assign bus_io.mem_to_wb_valid = mem_valid_q;
    assign bus_io.mem_to_wb_bus   = {pc, final_result, reg_we, waddr};
    assign bus_io.mem_to_id_bus   = {mem_valid_q && reg_we, waddr, final_result,
                                     mem_valid_q && res_from_mem};
endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus pushes expected WB payloads, a negedge
// monitor compares every presented WB payload against the queue head.
module tb_mem_stage;
    logic clk;
    logic resetn;

    mem_stage_if m ();

    mem_stage dut (
        .clk    (clk),
        .resetn (resetn),
        .bus_io (m.slave)
    );

    int vectors;
    int miscompares;
    logic [69:0] sb_q[$];

    typedef struct {
        logic [31:0] alu;
        logic [2:0]  op;
        logic [31:0] rdata;
        logic [31:0] exp;
    } ld_vec_t;

    ld_vec_t tbl[8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [73:0] act, input logic [73:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [73:0] mk_exe(input logic [31:0] pc, input logic [31:0] alu,
                                           input logic rfm, input logic [2:0] op,
                                           input logic we, input logic [4:0] wa);
        return {pc, alu, rfm, op, we, wa};
    endfunction

    function automatic logic [69:0] mk_wb(input logic [31:0] pc, input logic [31:0] res,
                                          input logic we, input logic [4:0] wa);
        return {pc, res, we, wa};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every valid WB cycle is compared; a transfer pops the head.
    always @(negedge clk) begin
        if (resetn && m.mem_to_wb_valid) begin
            if (sb_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL wb_unexpected: actual=%h required=none", m.mem_to_wb_bus);
            end else begin
                check("wb_bus", {4'd0, m.mem_to_wb_bus}, {4'd0, sb_q[0]});
                if (m.wb_allow_in) void'(sb_q.pop_front());
            end
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        tbl[0] = '{32'h1000_0000, 3'b001, 32'h0000_007F, 32'h0000_007F};
        tbl[1] = '{32'h1000_0001, 3'b001, 32'h0000_8000, 32'hFFFF_FF80};
        tbl[2] = '{32'h1000_0002, 3'b010, 32'h8001_0000, 32'hFFFF_8001};
        tbl[3] = '{32'h1000_0000, 3'b010, 32'h0000_7FFF, 32'h0000_7FFF};
        tbl[4] = '{32'h1000_0002, 3'b011, 32'h00FE_0000, 32'h0000_00FE};
        tbl[5] = '{32'h1000_0000, 3'b100, 32'h1234_ABCD, 32'h0000_ABCD};
        tbl[6] = '{32'h1000_0000, 3'b111, 32'hCAFE_BABE, 32'hCAFE_BABE};
        tbl[7] = '{32'h1000_0003, 3'b011, 32'hFF00_0000, 32'h0000_00FF};

        resetn               = 1'b0;
        m.exe_to_mem_valid   = 1'b0;
        m.exe_to_mem_bus     = '0;
        m.wb_allow_in        = 1'b1;
        m.data_sram_rdata    = '0;
        #3;
        check("rst_allow_in", {73'd0, m.mem_allow_in}, 74'd1);
        check("rst_wb_valid", {73'd0, m.mem_to_wb_valid}, 74'd0);
        check("rst_wb_bus", {4'd0, m.mem_to_wb_bus}, 74'd0);
        check("rst_id_bus", {35'd0, m.mem_to_id_bus}, 74'd0);
        step();
        resetn = 1'b1;

        // ld.b, byte 3 of 0x80FF0000
        step();
        m.exe_to_mem_valid = 1'b1;
        m.exe_to_mem_bus   = mk_exe(32'h1C00_0000, 32'h1000_0003, 1'b1, 3'b001, 1'b1, 5'd3);
        sb_q.push_back(mk_wb(32'h1C00_0000, 32'hFFFF_FF80, 1'b1, 5'd3));
        step();
        m.exe_to_mem_valid = 1'b0;
        m.data_sram_rdata  = 32'h80FF_0000;
        #2;
        check("ldb_id_bus", {35'd0, m.mem_to_id_bus},
              {35'd0, 1'b1, 5'd3, 32'hFFFF_FF80, 1'b1});

        // non-load ALU result forwarding
        step();
        m.exe_to_mem_valid = 1'b1;
        m.exe_to_mem_bus   = mk_exe(32'h1C00_0004, 32'h1234_5678, 1'b0, 3'b000, 1'b1, 5'd5);
        m.data_sram_rdata  = 32'h0;
        sb_q.push_back(mk_wb(32'h1C00_0004, 32'h1234_5678, 1'b1, 5'd5));
        step();
        m.exe_to_mem_valid = 1'b0;
        #2;
        check("alu_id_bus", {35'd0, m.mem_to_id_bus},
              {35'd0, 1'b1, 5'd5, 32'h1234_5678, 1'b0});

        // ld.hu stalled 3 cycles, with EXE presenting a new instruction during the stall
        step();
        m.exe_to_mem_valid = 1'b1;
        m.exe_to_mem_bus   = mk_exe(32'h1C00_0008, 32'h1000_0002, 1'b1, 3'b100, 1'b1, 5'd7);
        sb_q.push_back(mk_wb(32'h1C00_0008, 32'h0000_BEEF, 1'b1, 5'd7));
        step();
        m.exe_to_mem_valid = 1'b0;
        m.wb_allow_in      = 1'b0;
        m.data_sram_rdata  = 32'hBEEF_1234;
        step();
        m.exe_to_mem_valid = 1'b1;
        m.exe_to_mem_bus   = mk_exe(32'h1C00_000C, 32'hCAFE_F00D, 1'b0, 3'b000, 1'b1, 5'd9);
        sb_q.push_back(mk_wb(32'h1C00_000C, 32'hCAFE_F00D, 1'b1, 5'd9));
        m.data_sram_rdata  = 32'hDEAD_DEAD;
        #2;
        check("stall_allow_in_1", {73'd0, m.mem_allow_in}, 74'd0);
        step();
        #2;
        check("stall_allow_in_2", {73'd0, m.mem_allow_in}, 74'd0);
        step();
        m.wb_allow_in = 1'b1;
        step();
        m.exe_to_mem_valid = 1'b0;

        // back-to-back ld.w then ld.bu
        step();
        m.exe_to_mem_valid = 1'b1;
        m.exe_to_mem_bus   = mk_exe(32'h1C00_0010, 32'h1000_0000, 1'b1, 3'b000, 1'b1, 5'd10);
        sb_q.push_back(mk_wb(32'h1C00_0010, 32'h1122_3344, 1'b1, 5'd10));
        step();
        m.exe_to_mem_bus   = mk_exe(32'h1C00_0014, 32'h1000_0001, 1'b1, 3'b011, 1'b1, 5'd11);
        sb_q.push_back(mk_wb(32'h1C00_0014, 32'h0000_00AB, 1'b1, 5'd11));
        m.data_sram_rdata  = 32'h1122_3344;
        step();
        m.exe_to_mem_valid = 1'b0;
        m.data_sram_rdata  = 32'h0000_AB00;
        step();
        m.data_sram_rdata  = 32'h0;

        // streamed load-extract table
        for (int i = 0; i < 8; i++) begin
            step();
            m.exe_to_mem_valid = 1'b1;
            m.exe_to_mem_bus   = mk_exe(32'h1C00_0100 + 32'(i * 4), tbl[i].alu, 1'b1,
                                        tbl[i].op, 1'b1, 5'(i + 12));
            sb_q.push_back(mk_wb(32'h1C00_0100 + 32'(i * 4), tbl[i].exp, 1'b1, 5'(i + 12)));
            m.data_sram_rdata  = (i > 0) ? tbl[i-1].rdata : 32'h0;
        end
        step();
        m.exe_to_mem_valid = 1'b0;
        m.data_sram_rdata  = tbl[7].rdata;
        step();
        m.data_sram_rdata  = 32'h0;
        step();
        check("sb_drained", 74'(sb_q.size()), 74'd0);

        // asynchronous reset in the middle of a stall
        m.exe_to_mem_valid = 1'b1;
        m.exe_to_mem_bus   = mk_exe(32'h1C00_0018, 32'h1000_0000, 1'b1, 3'b000, 1'b1, 5'd30);
        sb_q.push_back(mk_wb(32'h1C00_0018, 32'hA5A5_A5A5, 1'b1, 5'd30));
        step();
        m.exe_to_mem_valid = 1'b0;
        m.wb_allow_in      = 1'b0;
        m.data_sram_rdata  = 32'hA5A5_A5A5;
        step();
        m.data_sram_rdata  = 32'h0;
        #2;
        check("pre_rst_valid", {73'd0, m.mem_to_wb_valid}, 74'd1);
        resetn = 1'b0;
        #1;
        check("mid_rst_wb_valid", {73'd0, m.mem_to_wb_valid}, 74'd0);
        check("mid_rst_allow_in", {73'd0, m.mem_allow_in}, 74'd1);
        check("mid_rst_id_bus", {35'd0, m.mem_to_id_bus}, 74'd0);
        check("mid_rst_wb_bus", {4'd0, m.mem_to_wb_bus}, 74'd0);
        sb_q.delete();
        step();
        resetn        = 1'b1;
        m.wb_allow_in = 1'b1;
        step();
        check("post_rst_valid", {73'd0, m.mem_to_wb_valid}, 74'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
